// File: rtl/iexecute.sv
// Execute stage of the 5-stage MIPS pipeline: control decode, operand forwarding,
// ALU, a multi-cycle signed multiplier writing HI/LO, beq resolution and the EX/MEM register.
module iexecute #(
  parameter int MULT_CYCLES = 4,
  parameter int PC_W        = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [5:0]      ip_opcode,
  input  logic [5:0]      ip_function_opcode,
  input  logic [PC_W-1:0] ip_PC_plus_4,
  input  logic [31:0]     ip_read_data_1,
  input  logic [31:0]     ip_read_data_2,
  input  logic [31:0]     ip_immediate,
  input  logic [4:0]      ip_dest_reg_R_type,
  input  logic [4:0]      ip_dest_reg_I_type,
  input  logic [4:0]      ip_dec_rs,
  input  logic [4:0]      ip_dec_rt,
  input  logic            ip_flush,
  input  logic            ip_wb_RegWrite,
  input  logic [4:0]      ip_wb_dest,
  input  logic [31:0]     ip_wb_data,
  output logic [31:0]     op_alu_result,
  output logic [31:0]     op_write_data,
  output logic [4:0]      op_dest_reg,
  output logic            op_RegWrite,
  output logic            op_MemRead,
  output logic            op_MemWrite,
  output logic            op_MemtoReg,
  output logic            op_zero,
  output logic            op_branch,
  output logic [PC_W-1:0] op_branch_target,
  output logic            op_busy
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  typedef enum logic {IDLE, MULT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_HI, ALU_LO} alu_op_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]     mult_a, mult_b, hi, lo;
  logic [63:0]     product;

  logic    reg_write, mem_read, mem_write, mem_to_reg;
  logic    is_beq, is_mult, use_imm, dest_is_i;
  alu_op_t alu_op;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    is_beq     = 1'b0;
    is_mult    = 1'b0;
    use_imm    = 1'b0;
    dest_is_i  = 1'b0;
    alu_op     = ALU_ADD;
    case (ip_opcode)
      6'h00: begin
        case (ip_function_opcode)
          6'h20: reg_write = 1'b1;
          6'h22: begin reg_write = 1'b1; alu_op = ALU_SUB; end
          6'h24: begin reg_write = 1'b1; alu_op = ALU_AND; end
          6'h25: begin reg_write = 1'b1; alu_op = ALU_OR;  end
          6'h2A: begin reg_write = 1'b1; alu_op = ALU_SLT; end
          6'h10: begin reg_write = 1'b1; alu_op = ALU_HI;  end
          6'h12: begin reg_write = 1'b1; alu_op = ALU_LO;  end
          6'h18: is_mult = 1'b1;
          default: ;
        endcase
      end
      6'h08: begin reg_write = 1'b1; use_imm = 1'b1; dest_is_i = 1'b1; end
      6'h23: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        use_imm    = 1'b1;
        dest_is_i  = 1'b1;
      end
      6'h2B: begin mem_write = 1'b1; use_imm = 1'b1; end
      6'h04: is_beq = 1'b1;
      default: ;
    endcase
  end

  // A load sitting in EX/MEM has no data yet; the hazard unit stalls for it instead.
  logic ex_fwd_en, wb_fwd_en;
  assign ex_fwd_en = op_RegWrite && !op_MemtoReg && (op_dest_reg != 5'd0);
  assign wb_fwd_en = ip_wb_RegWrite && (ip_wb_dest != 5'd0);

  function automatic logic [31:0] forward(
    input logic [4:0]  addr,
    input logic [31:0] reg_val,
    input logic        ex_en,
    input logic [4:0]  ex_dest,
    input logic [31:0] ex_val,
    input logic        wb_en,
    input logic [4:0]  wb_dest,
    input logic [31:0] wb_val
  );
    if (ex_en && ex_dest == addr)      return ex_val;
    else if (wb_en && wb_dest == addr) return wb_val;
    else                               return reg_val;
  endfunction

  logic [31:0]     opnd_a, opnd_b, alu_b, alu_result;
  logic [PC_W-1:0] branch_target;

  assign opnd_a = forward(ip_dec_rs, ip_read_data_1, ex_fwd_en, op_dest_reg, op_alu_result,
                          wb_fwd_en, ip_wb_dest, ip_wb_data);
  assign opnd_b = forward(ip_dec_rt, ip_read_data_2, ex_fwd_en, op_dest_reg, op_alu_result,
                          wb_fwd_en, ip_wb_dest, ip_wb_data);
  assign alu_b  = use_imm ? ip_immediate : opnd_b;
  assign branch_target = ip_PC_plus_4 + {ip_immediate[PC_W-3:0], 2'b00};

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD: alu_result = opnd_a + alu_b;
      ALU_SUB: alu_result = opnd_a - alu_b;
      ALU_AND: alu_result = opnd_a & alu_b;
      ALU_OR:  alu_result = opnd_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(opnd_a) < $signed(alu_b)};
      ALU_HI:  alu_result = hi;
      ALU_LO:  alu_result = lo;
      default: alu_result = 32'd0;
    endcase
  end

  // Sign-extending to 64 bits first makes the unsigned product equal the signed one.
  assign product = {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};

  logic start, bubble;
  assign start   = (state_q == IDLE) && is_mult && !ip_flush;
  assign bubble  = (state_q == MULT) || ip_flush || is_mult;
  assign op_busy = (state_q == MULT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MULT;
      MULT:    if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: HI/LO are architectural state and are cleared by reset like any other register;
  // a reset mid-multiply therefore discards the product.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mult_a  <= 32'd0;
      mult_b  <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (start) begin
        mult_a <= opnd_a;
        mult_b <= opnd_b;
        cnt_q  <= CNT_W'(MULT_CYCLES - 1);
      end else if (state_q == MULT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) {hi, lo} <= product;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_alu_result    <= 32'd0;
      op_write_data    <= 32'd0;
      op_dest_reg      <= 5'd0;
      op_RegWrite      <= 1'b0;
      op_MemRead       <= 1'b0;
      op_MemWrite      <= 1'b0;
      op_MemtoReg      <= 1'b0;
      op_zero          <= 1'b0;
      op_branch        <= 1'b0;
      op_branch_target <= '0;
    end else begin
      op_alu_result    <= alu_result;
      op_write_data    <= opnd_b;
      op_branch_target <= branch_target;
      if (bubble) begin
        op_dest_reg <= 5'd0;
        op_RegWrite <= 1'b0;
        op_MemRead  <= 1'b0;
        op_MemWrite <= 1'b0;
        op_MemtoReg <= 1'b0;
        op_zero     <= 1'b0;
        op_branch   <= 1'b0;
      end else begin
        op_dest_reg <= !reg_write ? 5'd0 :
                       dest_is_i  ? ip_dest_reg_I_type : ip_dest_reg_R_type;
        op_RegWrite <= reg_write;
        op_MemRead  <= mem_read;
        op_MemWrite <= mem_write;
        op_MemtoReg <= mem_to_reg;
        op_zero     <= (opnd_a == opnd_b);
        op_branch   <= is_beq;
      end
    end
  end

endmodule

// File: tb/tb_iexecute.sv
// Scoreboard bench for iexecute: directed scenarios then random instruction streams,
// each compared against an instruction-level reference model.
module tb_iexecute;

  localparam int MULT_CYCLES = 4;
  localparam int PC_W        = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic [5:0]      ip_opcode, ip_function_opcode;
  logic [PC_W-1:0] ip_PC_plus_4;
  logic [31:0]     ip_read_data_1, ip_read_data_2, ip_immediate, ip_wb_data;
  logic [4:0]      ip_dest_reg_R_type, ip_dest_reg_I_type, ip_dec_rs, ip_dec_rt, ip_wb_dest;
  logic            ip_flush, ip_wb_RegWrite;
  logic [31:0]     op_alu_result, op_write_data;
  logic [4:0]      op_dest_reg;
  logic            op_RegWrite, op_MemRead, op_MemWrite, op_MemtoReg, op_zero, op_branch, op_busy;
  logic [PC_W-1:0] op_branch_target;

  iexecute #(.MULT_CYCLES(MULT_CYCLES), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset),
    .ip_opcode(ip_opcode), .ip_function_opcode(ip_function_opcode),
    .ip_PC_plus_4(ip_PC_plus_4),
    .ip_read_data_1(ip_read_data_1), .ip_read_data_2(ip_read_data_2),
    .ip_immediate(ip_immediate),
    .ip_dest_reg_R_type(ip_dest_reg_R_type), .ip_dest_reg_I_type(ip_dest_reg_I_type),
    .ip_dec_rs(ip_dec_rs), .ip_dec_rt(ip_dec_rt), .ip_flush(ip_flush),
    .ip_wb_RegWrite(ip_wb_RegWrite), .ip_wb_dest(ip_wb_dest), .ip_wb_data(ip_wb_data),
    .op_alu_result(op_alu_result), .op_write_data(op_write_data), .op_dest_reg(op_dest_reg),
    .op_RegWrite(op_RegWrite), .op_MemRead(op_MemRead), .op_MemWrite(op_MemWrite),
    .op_MemtoReg(op_MemtoReg), .op_zero(op_zero), .op_branch(op_branch),
    .op_branch_target(op_branch_target), .op_busy(op_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            rst;
    logic [5:0]      opc, fn;
    logic [PC_W-1:0] pc;
    logic [31:0]     rd1, rd2, imm, wb_data;
    logic [4:0]      rd, rt_dst, rs, rt, wb_dest;
    logic            flush, wb_we;
  } stim_t;

  typedef struct {
    string           tag;
    logic            busy, rw, mr, mw, m2r, br, zero;
    logic [4:0]      dest;
    logic [31:0]     alu, wdata;
    logic [PC_W-1:0] tgt;
    bit              c_zero, c_dest, c_alu, c_wdata, c_tgt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural HI/LO, remaining multiply cycles, last forwardable result.
  bit          m_ex_fw;
  logic [4:0]  m_ex_dest;
  logic [31:0] m_ex_val, m_hi, m_lo, m_pa, m_pb;
  int          m_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t blank(input string tag);
    exp_t e;
    e.tag = tag;
    e.busy = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.br = 0; e.zero = 0;
    e.dest = 0; e.alu = 0; e.wdata = 0; e.tgt = 0;
    e.c_zero = 0; e.c_dest = 0; e.c_alu = 0; e.c_wdata = 0; e.c_tgt = 0;
    return e;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] rv,
                                          input stim_t s);
    if (m_ex_fw && m_ex_dest != 0 && m_ex_dest == addr) return m_ex_val;
    if (s.wb_we && s.wb_dest != 0 && s.wb_dest == addr) return s.wb_data;
    return rv;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    logic [31:0] a, b;
    longint      p;
    if (s.rst) begin
      e = blank("reset");
      e.c_zero = 1; e.c_dest = 1; e.c_alu = 1; e.c_wdata = 1; e.c_tgt = 1;
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      e = blank("mult_busy");
      e.c_zero = 1; e.c_dest = 1;
      m_left--;
      if (m_left == 0) begin
        p = longint'(signed'(m_pa)) * longint'(signed'(m_pb));
        {m_hi, m_lo} = p;
      end
    end else begin
      a = operand(s.rs, s.rd1, s);
      b = operand(s.rt, s.rd2, s);
      if (s.flush) begin
        e = blank("flush");
        e.c_zero = 1; e.c_dest = 1;
      end else if (s.opc == 6'h00 && s.fn == 6'h18) begin
        e = blank("mult_start");
        e.c_zero = 1; e.c_dest = 1;
        m_pa = a; m_pb = b; m_left = MULT_CYCLES - 1;
      end else begin
        e = blank("instr");
        e.wdata = b; e.c_wdata = 1;
        case (s.opc)
          6'h00: begin
            e.rw = 1; e.dest = s.rd; e.c_alu = 1;
            case (s.fn)
              6'h20: begin e.tag = "add";  e.alu = a + b; end
              6'h22: begin e.tag = "sub";  e.alu = a - b; end
              6'h24: begin e.tag = "and";  e.alu = a & b; end
              6'h25: begin e.tag = "or";   e.alu = a | b; end
              6'h2A: begin e.tag = "slt";  e.alu = (signed'(a) < signed'(b)) ? 1 : 0; end
              6'h10: begin e.tag = "mfhi"; e.alu = m_hi; end
              6'h12: begin e.tag = "mflo"; e.alu = m_lo; end
              default: begin e.tag = "bad_funct"; e.rw = 0; e.dest = 0; e.c_alu = 0; end
            endcase
          end
          6'h08: begin e.tag = "addi"; e.rw = 1; e.dest = s.rt_dst; e.alu = a + s.imm; e.c_alu = 1; end
          6'h23: begin
            e.tag = "lw"; e.rw = 1; e.mr = 1; e.m2r = 1; e.dest = s.rt_dst;
            e.alu = a + s.imm; e.c_alu = 1;
          end
          6'h2B: begin e.tag = "sw"; e.mw = 1; e.alu = a + s.imm; e.c_alu = 1; end
          6'h04: begin
            e.tag = "beq"; e.br = 1; e.zero = (a == b); e.c_zero = 1;
            e.tgt = s.pc + PC_W'(s.imm * 4); e.c_tgt = 1;
          end
          default: e.tag = "bad_opcode";
        endcase
        e.c_dest = e.rw;
      end
    end
    e.busy   = (m_left > 0);
    m_ex_fw   = e.rw && !e.m2r;
    m_ex_dest = e.dest;
    m_ex_val  = e.alu;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clock);
    reset = s.rst;
    ip_opcode = s.opc; ip_function_opcode = s.fn; ip_PC_plus_4 = s.pc;
    ip_read_data_1 = s.rd1; ip_read_data_2 = s.rd2; ip_immediate = s.imm;
    ip_dest_reg_R_type = s.rd; ip_dest_reg_I_type = s.rt_dst;
    ip_dec_rs = s.rs; ip_dec_rt = s.rt; ip_flush = s.flush;
    ip_wb_RegWrite = s.wb_we; ip_wb_dest = s.wb_dest; ip_wb_data = s.wb_data;
    @(posedge clock);
    model_step(s, e);
    sb.push_back(e);
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.rst = 0; s.opc = 6'h3F; s.fn = 0; s.pc = 0;
    s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.wb_data = 0;
    s.rd = 0; s.rt_dst = 0; s.rs = 0; s.rt = 0; s.wb_dest = 0;
    s.flush = 0; s.wb_we = 0;
    return s;
  endfunction

  function automatic stim_t r_type(input logic [5:0] fn, input logic [4:0] rs, rt, rd,
                                   input logic [31:0] rd1, rd2);
    stim_t s = nop();
    s.opc = 6'h00; s.fn = fn; s.rs = rs; s.rt = rt; s.rd = rd; s.rd1 = rd1; s.rd2 = rd2;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = nop();
    logic [5:0] fns [8];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h18};
    s.rst = ($urandom_range(0, 99) == 0);
    case ($urandom_range(0, 13))
      0, 1, 2, 3, 4, 5, 6, 7: begin s.opc = 6'h00; s.fn = fns[$urandom_range(0, 7)]; end
      8:  s.opc = 6'h08;
      9:  s.opc = 6'h23;
      10: s.opc = 6'h2B;
      11: s.opc = 6'h04;
      12: begin s.opc = 6'h00; s.fn = 6'h03; end
      default: s.opc = 6'h0F;
    endcase
    s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom_range(0, 3)); s.rt_dst = 5'($urandom_range(0, 3));
    s.rd1 = $urandom;
    s.rd2 = $urandom_range(0, 1) ? s.rd1 : $urandom;
    s.imm = $urandom; s.pc = PC_W'($urandom);
    s.flush = ($urandom_range(0, 9) == 0);
    s.wb_we = $urandom_range(0, 1); s.wb_dest = 5'($urandom_range(0, 3)); s.wb_data = $urandom;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".busy"},     op_busy,     e.busy);
        check({e.tag, ".RegWrite"}, op_RegWrite, e.rw);
        check({e.tag, ".MemRead"},  op_MemRead,  e.mr);
        check({e.tag, ".MemWrite"}, op_MemWrite, e.mw);
        check({e.tag, ".MemtoReg"}, op_MemtoReg, e.m2r);
        check({e.tag, ".branch"},   op_branch,   e.br);
        if (e.c_zero)  check({e.tag, ".zero"},       op_zero,          e.zero);
        if (e.c_dest)  check({e.tag, ".dest_reg"},   op_dest_reg,      e.dest);
        if (e.c_alu)   check({e.tag, ".alu_result"}, op_alu_result,    e.alu);
        if (e.c_wdata) check({e.tag, ".write_data"}, op_write_data,    e.wdata);
        if (e.c_tgt)   check({e.tag, ".target"},     op_branch_target, e.tgt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    m_ex_fw = 0; m_ex_dest = 0; m_ex_val = 0; m_hi = 0; m_lo = 0; m_pa = 0; m_pb = 0; m_left = 0;
    s = nop(); s.rst = 1;
    drive(s);
    drive(s);

    // add r1 = r2 + r3, then sub r4 = r1 - r2 with stale r1 and a competing MEM/WB r1.
    drive(r_type(6'h20, 5'd2, 5'd3, 5'd1, 32'd2, 32'd3));
    s = r_type(6'h22, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2);
    s.wb_we = 1; s.wb_dest = 5'd1; s.wb_data = 32'd9;
    drive(s);

    // beq taken, then the same beq flushed.
    s = nop(); s.opc = 6'h04; s.rs = 5'd5; s.rt = 5'd6; s.rd1 = 32'd7; s.rd2 = 32'd7;
    s.pc = PC_W'(10'h010); s.imm = 32'd3;
    drive(s);
    s.flush = 1;
    drive(s);

    // mult -3 * 5, busy cycles, then mflo / mfhi.
    drive(r_type(6'h18, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFD, 32'd5));
    repeat (MULT_CYCLES - 1) drive(nop());
    drive(r_type(6'h12, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0));
    drive(r_type(6'h10, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0));

    // Reset in the second cycle of a multiply clears HI/LO.
    drive(r_type(6'h18, 5'd7, 5'd8, 5'd0, 32'd1234, 32'd77));
    s = nop(); s.rst = 1;
    drive(s);
    drive(r_type(6'h10, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0));
    drive(r_type(6'h12, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0));

    // sw with store data forwarded from MEM/WB.
    s = nop(); s.opc = 6'h2B; s.rs = 5'd4; s.rt = 5'd5; s.rd1 = 32'd4; s.rd2 = 32'd0;
    s.imm = 32'd8; s.wb_we = 1; s.wb_dest = 5'd5; s.wb_data = 32'h0000_DEAD;
    drive(s);

    for (int i = 0; i < 600; i++) drive(rand_stim());

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iexecute.md
Name: iexecute

Overview:
Execute stage of the 5-stage pipelined MIPS core. It sits directly downstream of the decode stage and consumes that stage's registered outputs: opcode, funct, operands, immediate, dest regs, rs and rt.
- Derives control from the opcode and funct, forwards operands, and runs the ALU.
- Runs a multi-cycle signed multiplier that writes HI/LO.
- Resolves beq and registers everything into the EX/MEM pipeline register.
- The registered op_zero and op_branch outputs feed back to decode and fetch for flushing.

Parameters:
MULT_CYCLES, 4, cycles the multiplier occupies EX, including the accept cycle; minimum 2.
PC_W, 10, PC width, matching the decode-stage PC_plus_4.

Ports:
clock  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
ip_opcode  in  6  instruction[31:26] from decode.
ip_function_opcode  in  6  funct field from decode.
ip_PC_plus_4  in  PC_W  PC+4 from decode.
ip_read_data_1  in  32  rs register value.
ip_read_data_2  in  32  rt register value.
ip_immediate  in  32  sign-extended immediate.
ip_dest_reg_R_type  in  5  rd; decode forces this to 0 on a stall or flush.
ip_dest_reg_I_type  in  5  rt used as destination.
ip_dec_rs  in  5  rs address, for forwarding.
ip_dec_rt  in  5  rt address, for forwarding.
ip_flush  in  1  turns the current EX instruction into a bubble.
ip_wb_RegWrite  in  1  MEM/WB write enable.
ip_wb_dest  in  5  MEM/WB destination register.
ip_wb_data  in  32  MEM/WB write-back data.
op_alu_result  out  32  registered ALU or HI/LO result, or memory address.
op_write_data  out  32  registered forwarded rt value, used as store data.
op_dest_reg  out  5  registered destination register.
op_RegWrite  out  1  registered control.
op_MemRead  out  1  registered control.
op_MemWrite  out  1  registered control.
op_MemtoReg  out  1  registered control.
op_zero  out  1  registered: operand A equals operand B.
op_branch  out  1  registered: instruction is beq.
op_branch_target  out  PC_W  registered branch target.
op_busy  out  1  combinational: multiplier active; the hazard unit freezes IF/ID while it is high.

Behaviour:
- Reset: every registered output is 0, HI = LO = 0, FSM goes to IDLE, op_busy = 0. A reset during a multiply aborts it with no HI/LO write.
- Latency: one cycle from the inputs to the EX/MEM outputs.

Decoded instructions:
- opcode 0x00 (R-type), by funct:
  - add 0x20, sub 0x22, and 0x24, or 0x25: RegWrite to ip_dest_reg_R_type.
  - slt 0x2A: signed compare, result 1 or 0, RegWrite to ip_dest_reg_R_type.
  - mfhi 0x10, mflo 0x12: result is HI or LO, RegWrite to ip_dest_reg_R_type.
  - mult 0x18: starts the multiplier; no RegWrite.
- I-type:
  - addi 0x08: rs + immediate, RegWrite to ip_dest_reg_I_type.
  - lw 0x23: address = rs + immediate; MemRead=1, MemtoReg=1, RegWrite to ip_dest_reg_I_type.
  - sw 0x2B: address = rs + immediate; MemWrite=1.
  - beq 0x04: branch=1, zero = (A == B); no RegWrite.
- Any other encoding is a bubble: all controls 0.
- Arithmetic wraps modulo 2^32. Overflow is ignored.

Forwarding (applied separately to operand A/rs and operand B/rt):
- Priority 1, EX/MEM: this block's own registered op_alu_result, when op_RegWrite=1, op_MemtoReg=0, op_dest_reg != 0 and op_dest_reg matches the address.
- Priority 2, MEM/WB: ip_wb_data, when ip_wb_RegWrite=1, ip_wb_dest != 0 and ip_wb_dest matches the address.
- Otherwise the ip_read_data value is used.
- A lw result in EX/MEM is never forwarded; the hazard unit stalls for it.
- The ALU B input is the immediate for addi, lw and sw; op_write_data is always the forwarded rt value.

Branch:
- op_branch_target = ip_PC_plus_4 + (immediate << 2), truncated to PC_W bits.
- op_zero is registered for every instruction. Consumers qualify it with op_branch.

Bubbles:
- ip_flush=1 forces RegWrite, MemRead, MemWrite, MemtoReg, branch and zero to 0 and op_dest_reg to 0. Data outputs are don't-care.
- Flush takes priority over a mult start: the multiplier does not start.

Multiplier FSM:
- States are IDLE and MULT.
- IDLE to MULT: a valid, unflushed mult while IDLE. This latches the forwarded A and B as signed values and loads a counter with MULT_CYCLES-1. The EX/MEM register receives a bubble.
- While in MULT:
  - op_busy=1 and all ip_* inputs are ignored, including ip_flush.
  - EX/MEM receives a bubble every cycle.
  - The counter decrements each cycle.
- MULT to IDLE: when the counter is 1. On that edge {HI,LO} takes the signed 64-bit product A*B.
- Net effect: the mult occupies MULT_CYCLES cycles, and a following mfhi or mflo sees the new value.

Test Plan:
- Reset, then add with rs=2 (value 2), rt=3 (value 3), rd=1 -> next cycle op_alu_result=5, op_dest_reg=1, op_RegWrite=1; all outputs 0 while reset is held.
- Back-to-back: add r1=r2+r3, then sub r4=r1-r2 with decode's stale r1=1 -> EX/MEM forward gives op_alu_result=3. With ip_wb_dest=1 and ip_wb_data=9 also present, EX/MEM still wins.
- beq with A=B=7, PC_plus_4=0x010, immediate=3 -> op_zero=1, op_branch=1, op_branch_target=0x01C. Same beq with ip_flush=1 -> op_branch=0, op_zero=0.
- mult A=-3, B=5 with MULT_CYCLES=4 -> op_busy high 3 cycles, bubbles at the outputs; then mflo returns 0xFFFFFFF1 and mfhi returns 0xFFFFFFFF.
- Reset asserted in the 2nd cycle of a multiply -> FSM IDLE, op_busy=0, HI=LO=0.
- sw with rs=4, immediate=8, rt forwarded from MEM/WB data 0xDEAD -> op_alu_result=12, op_write_data=0xDEAD, op_MemWrite=1, op_RegWrite=0.
